// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Latency: not applicable (package only).
// Backpressure: not applicable (package only).
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_NIB_W   = 4;
    localparam int ADD3_THRESH = 5;

    // Decimal digits needed to hold any bin_w-bit unsigned value:
    // ceil(bin_w * log10(2)), with log10(2) taken as 0.30103.
    function automatic int min_digits(input int bin_w);
        return (bin_w * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 (mod 16).
// Latency: purely combinational.
// Backpressure: none, no state.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [BCD_NIB_W-1:0] digit,
    output logic [BCD_NIB_W-1:0] adj
);

    // Pre-shift correction so the following doubling carries decimally.
    always_comb begin
        adj = digit;
        if (digit >= BCD_NIB_W'(ADD3_THRESH)) begin
            adj = digit + BCD_NIB_W'(3);
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Latency: BIN_W cycles from acceptance to out_valid; issue interval BIN_W+2.
// Backpressure: result held frozen in DONE until out_ready; in_ready only in IDLE.
// Optional build macro BIN2BCD_SIGNED_EN: two's complement input, adds out_neg.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [BIN_W-1:0]              in_bin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BCD_NIB_W*DIGITS-1:0]   out_bcd,
    output logic                          out_ovf
`ifdef BIN2BCD_SIGNED_EN
    ,
    output logic                          out_neg
`endif
);

    localparam int BCD_W = BCD_NIB_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    state_t             state;
    state_t             state_nxt;
    logic [BIN_W-1:0]   bin_sr;
    logic [BIN_W-1:0]   load_val;
    logic [BCD_W-1:0]   bcd_sr;
    logic [BCD_W-1:0]   bcd_adj;
    logic [CNT_W-1:0]   cnt;
    logic               ovf;
    logic               accept;

    // All digits are corrected in parallel from their pre-step values.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit (bcd_sr [g*BCD_NIB_W +: BCD_NIB_W]),
            .adj   (bcd_adj[g*BCD_NIB_W +: BCD_NIB_W])
        );
    end

    // Value loaded into the shifter: raw operand, or its magnitude when signed.
    // Negation is mod 2^BIN_W so the most negative value comes out as its
    // unsigned magnitude.
    always_comb begin
        load_val = in_bin;
`ifdef BIN2BCD_SIGNED_EN
        if (in_bin[BIN_W-1]) begin
            load_val = ~in_bin + BIN_W'(1);
        end
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; in_ready is masked by rst so nothing
    // can be accepted while the block is being reset.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = ~rst;
                if (in_valid && !rst) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CNT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign accept = in_valid && in_ready;

    // Datapath: load on acceptance, then one corrected left shift per SHIFT cycle.
    // The BCD register doubles as the output register, so it keeps its last
    // value in IDLE and is only cleared by reset or the next acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_sr <= '0;
            bcd_sr <= '0;
            ovf    <= 1'b0;
            cnt    <= '0;
        end else if (accept) begin
            bin_sr <= load_val;
            bcd_sr <= '0;
            ovf    <= 1'b0;
            cnt    <= CNT_W'(BIN_W);
        end else if (state == SHIFT) begin
            bcd_sr <= {bcd_adj[BCD_W-2:0], bin_sr[BIN_W-1]};
            bin_sr <= {bin_sr[BIN_W-2:0], 1'b0};
            ovf    <= ovf | bcd_adj[BCD_W-1];
            cnt    <= cnt - CNT_W'(1);
        end
    end

    assign out_bcd = bcd_sr;
    assign out_ovf = ovf;

`ifdef BIN2BCD_SIGNED_EN
    logic neg;

    // Sign captured at acceptance, held through DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            neg <= 1'b0;
        end else if (accept) begin
            neg <= in_bin[BIN_W-1];
        end
    end

    assign out_neg = neg;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: a 3-digit and a 2-digit instance, both BIN_W=8,
// checked against a decimal reference model built from plain arithmetic.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    logic        a_valid = 1'b0, a_ready, a_ovalid, a_oready = 1'b1, a_ovf;
    logic [7:0]  a_bin = '0;
    logic [11:0] a_bcd;
    logic        b_valid = 1'b0, b_ready, b_ovalid, b_oready = 1'b1, b_ovf;
    logic [7:0]  b_bin = '0;
    logic [7:0]  b_bcd;
`ifdef BIN2BCD_SIGNED_EN
    logic        a_neg, b_neg;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_valid), .in_ready(a_ready), .in_bin(a_bin),
        .out_valid(a_ovalid), .out_ready(a_oready),
        .out_bcd(a_bcd), .out_ovf(a_ovf)
`ifdef BIN2BCD_SIGNED_EN
        , .out_neg(a_neg)
`endif
    );

    bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_valid), .in_ready(b_ready), .in_bin(b_bin),
        .out_valid(b_ovalid), .out_ready(b_oready),
        .out_bcd(b_bcd), .out_ovf(b_ovf)
`ifdef BIN2BCD_SIGNED_EN
        , .out_neg(b_neg)
`endif
    );

    // Reference: decimal digits of the (magnitude of the) operand, mod 10^digits.
    function automatic void model(input logic [7:0] v, input int digits,
                                  output logic [39:0] bcd, output logic ovf,
                                  output logic neg);
        int unsigned mag, lim, r;
        mag = int'(v);
        neg = 1'b0;
`ifdef BIN2BCD_SIGNED_EN
        if (v[7]) begin
            neg = 1'b1;
            mag = 256 - int'(v);
        end
`endif
        lim = 1;
        for (int i = 0; i < digits; i++) lim = lim * 10;
        ovf = (mag >= lim);
        r = mag % lim;
        bcd = '0;
        for (int i = 0; i < digits; i++) begin
            bcd[4*i +: 4] = 4'(r % 10);
            r = r / 10;
        end
    endfunction

    // Drives one conversion on instance sel (0=3-digit, 1=2-digit); called and
    // returns at a falling edge, returning at the first cycle out_valid is seen.
    task automatic run(input int sel, input logic [7:0] v,
                       output logic [11:0] bcd, output logic ovf, output logic neg,
                       output int lat, output logic ok);
        int w;
        ok = 1'b1;
        lat = 0;
        w = 0;
        while (!(sel == 0 ? a_ready : b_ready) && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) ok = 1'b0;
        if (sel == 0) begin a_valid = 1'b1; a_bin = v; end
        else          begin b_valid = 1'b1; b_bin = v; end
        @(posedge clk);
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
        while (!(sel == 0 ? a_ovalid : b_ovalid) && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 50) ok = 1'b0;
        bcd = (sel == 0) ? a_bcd : {4'd0, b_bcd};
        ovf = (sel == 0) ? a_ovf : b_ovf;
        neg = 1'b0;
`ifdef BIN2BCD_SIGNED_EN
        neg = (sel == 0) ? a_neg : b_neg;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (a_ready !== 1'b0 || a_ovalid !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold: ready=%b valid=%b required 0 0", a_ready, a_ovalid);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b1 || a_ovalid !== 1'b0 || a_bcd !== 12'h000 || a_ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: ready=%b valid=%b bcd=%h ovf=%b required 1 0 000 0",
                     a_ready, a_ovalid, a_bcd, a_ovf);
        end
        checks++;
        if (b_ready !== 1'b1 || b_ovalid !== 1'b0 || b_bcd !== 8'h00 || b_ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_state_b: ready=%b valid=%b bcd=%h ovf=%b required 1 0 00 0",
                     b_ready, b_ovalid, b_bcd, b_ovf);
        end
`ifdef BIN2BCD_SIGNED_EN
        checks++;
        if (a_neg !== 1'b0) begin
            failures++;
            $display("FAIL reset_neg: got %b required 0", a_neg);
        end
`endif
    endtask

    // Shared body for directed + random conversions on one instance.
    task automatic test_convert(input int sel, input int digits, input logic [7:0] vec[$]);
        logic [11:0] bcd;
        logic [39:0] e_bcd;
        logic        ovf, neg, e_ovf, e_neg, ok;
        int          lat;
        foreach (vec[k]) begin
            model(vec[k], digits, e_bcd, e_ovf, e_neg);
            run(sel, vec[k], bcd, ovf, neg, lat, ok);
            checks++;
            if (ok !== 1'b1 || lat != 8) begin
                failures++;
                $display("FAIL latency[%0d] in=%0d: ok=%b latency=%0d required ok=1 latency=8",
                         sel, vec[k], ok, lat);
            end
            checks++;
            if (bcd !== e_bcd[11:0] || ovf !== e_ovf) begin
                failures++;
                $display("FAIL convert[%0d] in=%0d: bcd=%h ovf=%b required bcd=%h ovf=%b",
                         sel, vec[k], bcd, ovf, e_bcd[11:0], e_ovf);
            end
`ifdef BIN2BCD_SIGNED_EN
            checks++;
            if (neg !== e_neg) begin
                failures++;
                $display("FAIL neg[%0d] in=%0d: got %b required %b", sel, vec[k], neg, e_neg);
            end
`endif
        end
    endtask

    task automatic test_three_digit();
        logic [7:0] vec[$];
        vec = '{8'd255, 8'd0, 8'd128, 8'd127, 8'd100};
        for (int i = 0; i < 12; i++) vec.push_back(8'($urandom_range(0, 255)));
        test_convert(0, 3, vec);
    endtask

    task automatic test_two_digit();
        logic [7:0] vec[$];
        vec = '{8'd99, 8'd200, 8'd137, 8'd100, 8'd9};
        for (int i = 0; i < 10; i++) vec.push_back(8'($urandom_range(0, 255)));
        test_convert(1, 2, vec);
    endtask

    task automatic test_backpressure();
        logic [11:0] bcd, held;
        logic        ovf, neg, ok;
        int          lat;
        a_oready = 1'b0;
        run(0, 8'd42, bcd, ovf, neg, lat, ok);
        checks++;
        if (ok !== 1'b1 || bcd !== 12'h042 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL bp_result: ok=%b bcd=%h ovf=%b required 1 042 0", ok, bcd, ovf);
        end
        held = bcd;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (a_ovalid !== 1'b1 || a_ready !== 1'b0 || a_bcd !== held) begin
                failures++;
                $display("FAIL bp_hold: valid=%b ready=%b bcd=%h required 1 0 %h",
                         a_ovalid, a_ready, a_bcd, held);
            end
        end
        a_oready = 1'b1;
        @(negedge clk);
        checks++;
        if (a_ovalid !== 1'b0 || a_ready !== 1'b1 || a_bcd !== 12'h042) begin
            failures++;
            $display("FAIL bp_release: valid=%b ready=%b bcd=%h required 0 1 042",
                     a_ovalid, a_ready, a_bcd);
        end
    endtask

    task automatic test_back_to_back();
        int          acc[$];
        logic [11:0] res[$];
        @(negedge clk);
        a_valid = 1'b1;
        a_bin   = 8'd7;
        for (int i = 0; i < 60 && res.size() < 2; i++) begin
            if (a_ovalid) begin
                res.push_back(a_bcd);
                if (res.size() == 1) a_bin = 8'd123;
                else                 a_valid = 1'b0;
            end else if (a_ready) begin
                acc.push_back(cyc + 1);
            end else begin
                a_bin = 8'($urandom_range(0, 255));
            end
            @(negedge clk);
        end
        a_valid = 1'b0;
        checks++;
        if (res.size() != 2 || acc.size() != 2) begin
            failures++;
            $display("FAIL b2b_count: results=%0d accepts=%0d required 2 2", res.size(), acc.size());
        end else begin
            checks++;
            if (res[0] !== 12'h007 || res[1] !== 12'h123) begin
                failures++;
                $display("FAIL b2b_data: got %h,%h required 007,123", res[0], res[1]);
            end
            checks++;
            if (acc[1] - acc[0] != 10) begin
                failures++;
                $display("FAIL b2b_interval: got %0d required 10", acc[1] - acc[0]);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [11:0] bcd;
        logic        ovf, neg, ok;
        int          lat, seen;
        a_valid = 1'b1;
        a_bin   = 8'd250;
        @(posedge clk);             // acceptance edge T
        @(negedge clk);
        a_valid = 1'b0;
        repeat (3) @(negedge clk);  // after T+1..T+3
        rst = 1'b1;                 // sampled at T+4
        @(negedge clk);
        checks++;
        if (a_ready !== 1'b0) begin
            failures++;
            $display("FAIL abort_ready_in_rst: got %b required 0", a_ready);
        end
        rst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (a_ovalid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0 || a_bcd !== 12'h000) begin
            failures++;
            $display("FAIL abort_no_output: valid_cycles=%0d bcd=%h required 0 000", seen, a_bcd);
        end
        run(0, 8'd19, bcd, ovf, neg, lat, ok);
        checks++;
        if (ok !== 1'b1 || bcd !== 12'h019 || ovf !== 1'b0 || lat != 8) begin
            failures++;
            $display("FAIL abort_next: ok=%b bcd=%h ovf=%b lat=%0d required 1 019 0 8",
                     ok, bcd, ovf, lat);
        end
    endtask

    task automatic test_signed_corners();
        logic [7:0] vec[$];
        vec = '{8'h80, 8'hFF, 8'h7F, 8'h81};
        test_convert(0, 3, vec);
    endtask

    initial begin
        test_reset();
        test_three_digit();
        test_two_digit();
        test_backpressure();
        test_back_to_back();
        test_reset_abort();
        test_signed_corners();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
